// File: rtl/shift_exec_stage_pkg.sv
// Shared encodings and types for the shift execute stage: op codes, shifter
// control conventions, and the registered response layout.
package shift_exec_stage_pkg;

    localparam int W         = 32;
    localparam int SHAMT_W   = $clog2(W);
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        SH_SLL  = 3'd0,
        SH_SRL  = 3'd1,
        SH_SRA  = 3'd2,
        SH_SLLV = 3'd3,
        SH_SRLV = 3'd4,
        SH_SRAV = 3'd5
    } sh_op_e;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic TYPE_LOG   = 1'b0;
    localparam logic TYPE_ARITH = 1'b1;

    typedef struct packed {
        logic legal;
        logic use_rt;
        logic dir;
        logic typ;
    } sh_ctl_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [4:0]   rd;
        logic         carry;
        logic         zero;
        logic         sign;
        logic         err;
    } sh_rsp_t;

    // Ops 3..5 take the amount from rt; arithmetic only matters for right shifts.
    function automatic sh_ctl_t decode_op(input logic [2:0] op);
        sh_ctl_t c;
        c.legal  = 1'b1;
        c.use_rt = 1'b0;
        c.dir    = DIR_LEFT;
        c.typ    = TYPE_LOG;
        case (op)
            SH_SLL:  ;
            SH_SRL:  c.dir = DIR_RIGHT;
            SH_SRA:  begin c.dir = DIR_RIGHT; c.typ = TYPE_ARITH; end
            SH_SLLV: c.use_rt = 1'b1;
            SH_SRLV: begin c.use_rt = 1'b1; c.dir = DIR_RIGHT; end
            SH_SRAV: begin c.use_rt = 1'b1; c.dir = DIR_RIGHT; c.typ = TYPE_ARITH; end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Operand-in / result-out channel of the shift execute stage, plus flush and
// the retired-shift counter.
interface shift_exec_stage_if
    import shift_exec_stage_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [W-1:0]       in_rs;
    logic [W-1:0]       in_rt;
    logic [4:0]         in_imm;
    logic [4:0]         in_rd;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [4:0]         out_rd;
    logic               out_carry;
    logic               out_zero;
    logic               out_sign;
    logic               out_err;
    logic [CNT_W-1:0]   shift_cnt;

    modport master (
        output flush, in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_carry, out_zero,
               out_sign, out_err, shift_cnt
    );

    modport slave (
        input  flush, in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_carry, out_zero,
               out_sign, out_err, shift_cnt
    );

endinterface

// File: rtl/shift_exec_stage_shifter.sv
// Combinational barrel shifter: type 0 logical / 1 arithmetic, dir 0 left / 1 right.
module shift_exec_stage_shifter
    import shift_exec_stage_pkg::*;
(
    input  logic [W-1:0]       a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               sh_type,
    input  logic               dir,
    output logic [W-1:0]       out
);

    // Kept as separate branches so the arithmetic shift stays in signed context.
    always_comb begin
        out = a << shamt;
        if (dir == DIR_RIGHT) begin
            if (sh_type == TYPE_ARITH) begin
                out = $signed(a) >>> shamt;
            end else begin
                out = a >> shamt;
            end
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute stage for shift ops: decode, shifter, carry/flags, one-deep
// valid/ready output register and a saturating retired-shift counter.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    shift_exec_stage_if.slave bus
);

    sh_ctl_t              ctl;
    logic [SHAMT_W-1:0]   shamt;
    logic [SHAMT_W-1:0]   carry_idx;
    logic [W-1:0]         sh_out;
    logic                 carry_c;
    sh_rsp_t              rsp_d;
    sh_rsp_t              rsp_q;
    logic                 vld_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 take_in;
    logic                 take_out;
    logic                 unused_rt_hi;

    assign ctl          = decode_op(bus.in_op);
    assign shamt        = ctl.use_rt ? bus.in_rt[SHAMT_W-1:0] : bus.in_imm;
    assign unused_rt_hi = ^bus.in_rt[W-1:SHAMT_W];

    shift_exec_stage_shifter u_shifter (
        .a       (bus.in_rs),
        .shamt   (shamt),
        .sh_type (ctl.typ),
        .dir     (ctl.dir),
        .out     (sh_out)
    );

    // Carry is the last bit to leave: rs[W-s] going left, rs[s-1] going right.
    always_comb begin
        carry_idx = (ctl.dir == DIR_LEFT) ? SHAMT_W'(W - int'(shamt))
                                          : shamt - SHAMT_W'(1);
        carry_c   = (shamt != '0) && bus.in_rs[carry_idx];
    end

    always_comb begin
        rsp_d     = '0;
        rsp_d.rd  = bus.in_rd;
        rsp_d.err = !ctl.legal;
        if (ctl.legal) begin
            rsp_d.data  = sh_out;
            rsp_d.carry = carry_c;
            rsp_d.zero  = (sh_out == '0);
            rsp_d.sign  = sh_out[W-1];
        end
    end

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign take_in      = bus.in_valid && bus.in_ready && !bus.flush;
    assign take_out     = vld_q && bus.out_ready;

    // Flush beats any load; a load in the same cycle as a consume keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (take_in) begin
            vld_q <= 1'b1;
            rsp_q <= rsp_d;
        end else if (take_out) begin
            vld_q <= 1'b0;
        end
    end

    // A consume still counts when it coincides with a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (take_out && !rsp_q.err && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_data  = rsp_q.data;
    assign bus.out_rd    = rsp_q.rd;
    assign bus.out_carry = rsp_q.carry;
    assign bus.out_zero  = rsp_q.zero;
    assign bus.out_sign  = rsp_q.sign;
    assign bus.out_err   = rsp_q.err;
    assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: directed literal cases plus randomized traffic
// checked every cycle against a wide-arithmetic reference model.
module tb_shift_exec_stage;

    logic clk;
    logic rst;

    shift_exec_stage_if #(.CNT_W(16)) bus16 ();
    shift_exec_stage_if #(.CNT_W(2))  bus2 ();

    assign bus2.flush     = bus16.flush;
    assign bus2.in_valid  = bus16.in_valid;
    assign bus2.in_op     = bus16.in_op;
    assign bus2.in_rs     = bus16.in_rs;
    assign bus2.in_rt     = bus16.in_rt;
    assign bus2.in_imm    = bus16.in_imm;
    assign bus2.in_rd     = bus16.in_rd;
    assign bus2.out_ready = bus16.out_ready;

    shift_exec_stage #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    shift_exec_stage #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shifts done in a 64-bit window so the carry falls out naturally.
    typedef struct {
        bit        v;
        bit [31:0] data;
        bit [4:0]  rd;
        bit        c;
        bit        z;
        bit        s;
        bit        e;
    } mdl_t;

    mdl_t m;
    int   m_cnt16 = 0;
    int   m_cnt2  = 0;

    function automatic mdl_t model_op(input bit [2:0] op, input bit [31:0] rs, input bit [31:0] rt,
                                      input bit [4:0] imm, input bit [4:0] rd);
        mdl_t r;
        int unsigned s;
        bit [63:0] t;
        logic signed [63:0] ts;
        r = '{default: 0};
        r.v  = 1;
        r.rd = rd;
        s = (op < 3) ? imm : (rt % 32);
        case (op)
            3'd0, 3'd3: begin
                t = {32'h0, rs} << s;
                r.data = t[31:0];
                r.c = t[32];
            end
            3'd1, 3'd4: begin
                t = {rs, 32'h0} >> s;
                r.data = t[63:32];
                r.c = t[31];
            end
            3'd2, 3'd5: begin
                ts = {rs, 32'h0};
                ts = ts >>> s;
                r.data = ts[63:32];
                r.c = ts[31];
            end
            default: r.e = 1;
        endcase
        if (!r.e) begin
            r.z = (r.data == 0);
            r.s = r.data[31];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: 0};
            m_cnt16 = 0;
            m_cnt2 = 0;
        end else begin
            if (m.v && bus16.out_ready && !m.e) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (bus16.flush)
                m.v = 0;
            else if (bus16.in_valid && (!m.v || bus16.out_ready))
                m = model_op(bus16.in_op, bus16.in_rs, bus16.in_rt, bus16.in_imm, bus16.in_rd);
            else if (m.v && bus16.out_ready)
                m.v = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", bus16.in_ready, !m.v || bus16.out_ready);
            chk("in_ready_c2", bus2.in_ready, !m.v || bus16.out_ready);
            chk("out_valid", bus16.out_valid, m.v);
            chk("out_valid_c2", bus2.out_valid, m.v);
            if (m.v) begin
                chk("out_data", bus16.out_data, m.data);
                chk("out_rd", bus16.out_rd, m.rd);
                chk("out_carry", bus16.out_carry, m.c);
                chk("out_zero", bus16.out_zero, m.z);
                chk("out_sign", bus16.out_sign, m.s);
                chk("out_err", bus16.out_err, m.e);
                chk("out_data_c2", bus2.out_data, m.data);
            end
            chk("shift_cnt", bus16.shift_cnt, m_cnt16);
            chk("shift_cnt_c2", bus2.shift_cnt, m_cnt2);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] imm, input logic [4:0] rd, input logic ordy);
        #1;
        bus16.in_valid  = 1;
        bus16.in_op     = op;
        bus16.in_rs     = rs;
        bus16.in_rt     = rt;
        bus16.in_imm    = imm;
        bus16.in_rd     = rd;
        bus16.out_ready = ordy;
        bus16.flush     = 0;
    endtask

    task automatic idle(input logic ordy);
        #1;
        bus16.in_valid  = 0;
        bus16.out_ready = ordy;
        bus16.flush     = 0;
    endtask

    task automatic chk_out(input string n, input logic [31:0] d, input logic [4:0] rd,
                           input logic c, input logic z, input logic s, input logic e);
        chk({n, ".valid"}, bus16.out_valid, 1);
        chk({n, ".data"},  bus16.out_data, d);
        chk({n, ".rd"},    bus16.out_rd, rd);
        chk({n, ".carry"}, bus16.out_carry, c);
        chk({n, ".zero"},  bus16.out_zero, z);
        chk({n, ".sign"},  bus16.out_sign, s);
        chk({n, ".err"},   bus16.out_err, e);
    endtask

    task automatic chk_zeroed(input string n);
        chk({n, ".valid"}, bus16.out_valid, 0);
        chk({n, ".data"},  bus16.out_data, 0);
        chk({n, ".rd"},    bus16.out_rd, 0);
        chk({n, ".flags"}, {bus16.out_carry, bus16.out_zero, bus16.out_sign, bus16.out_err}, 0);
        chk({n, ".cnt"},   bus16.shift_cnt, 0);
        chk({n, ".cnt_c2"}, bus2.shift_cnt, 0);
        chk({n, ".in_ready"}, bus16.in_ready, 1);
    endtask

    initial begin
        rst = 1;
        bus16.flush = 0; bus16.in_valid = 0; bus16.in_op = 0; bus16.in_rs = 0;
        bus16.in_rt = 0; bus16.in_imm = 0; bus16.in_rd = 0; bus16.out_ready = 0;
        @(posedge clk);
        cmp_en = 1;
        step();
        chk_zeroed("reset");
        #1 rst = 0;

        // Immediate and variable forms, carry and flag corners
        send(3'd0, 32'h8000_0000, 0, 5'd3, 5'd7, 1); step();
        chk_out("sll_msb", 32'h0, 5'd7, 0, 1, 0, 0);
        send(3'd2, 32'h8000_0000, 0, 5'd1, 5'd9, 1); step();
        chk_out("sra1", 32'hC000_0000, 5'd9, 0, 0, 1, 0);
        send(3'd1, 32'h8000_0000, 0, 5'd1, 5'd10, 1); step();
        chk_out("srl1", 32'h4000_0000, 5'd10, 0, 0, 0, 0);
        send(3'd3, 32'h3, 32'hFFFF_FFE1, 5'd0, 5'd11, 1); step();
        chk_out("sllv_s1", 32'h6, 5'd11, 0, 0, 0, 0);
        send(3'd3, 32'h3, 32'h1F, 5'd0, 5'd12, 1); step();
        chk_out("sllv_s31", 32'h8000_0000, 5'd12, 1, 0, 1, 0);
        send(3'd5, 32'h8000_0001, 32'h20, 5'd9, 5'd13, 1); step();
        chk_out("srav_s0", 32'h8000_0001, 5'd13, 0, 0, 1, 0);
        send(3'd4, 32'h10, 32'h5, 5'd0, 5'd14, 1); step();
        chk_out("srlv_carry", 32'h0, 5'd14, 1, 1, 0, 0);

        // Backpressure: hold A for three cycles, then retire back-to-back
        #1 rst = 1; bus16.in_valid = 0; step(); #1 rst = 0;
        send(3'd0, 32'h1, 0, 5'd1, 5'd1, 1); step();
        send(3'd0, 32'h1, 0, 5'd2, 5'd2, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", bus16.in_ready, 0);
            chk_out("bp_hold", 32'h2, 5'd1, 0, 0, 0, 0);
        end
        send(3'd0, 32'h1, 0, 5'd2, 5'd2, 1); step();
        chk_out("bp_b", 32'h4, 5'd2, 0, 0, 0, 0);
        send(3'd0, 32'h1, 0, 5'd3, 5'd3, 1); step();
        chk_out("bp_c", 32'h8, 5'd3, 0, 0, 0, 0);
        idle(1); step();
        chk("bp_drained", bus16.out_valid, 0);
        chk("bp_cnt", bus16.shift_cnt, 3);

        // Illegal op and flush
        send(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 5'd20, 1); step();
        chk_out("illegal", 32'h0, 5'd20, 0, 0, 0, 1);
        idle(1); step();
        chk("illegal_cnt", bus16.shift_cnt, 3);
        send(3'd0, 32'h1, 0, 5'd4, 5'd21, 0); step();
        send(3'd0, 32'h5, 0, 5'd0, 5'd22, 0); bus16.flush = 1; step();
        chk("flush_valid", bus16.out_valid, 0);
        chk("flush_cnt", bus16.shift_cnt, 3);
        idle(1); step();
        chk("flush_discard", bus16.out_valid, 0);
        send(3'd0, 32'h1, 0, 5'd1, 5'd23, 0); step();
        send(3'd0, 32'h1, 0, 5'd1, 5'd24, 1); bus16.flush = 1; step();
        chk("flush_consume_valid", bus16.out_valid, 0);
        chk("flush_consume_cnt", bus16.shift_cnt, 4);
        send(3'd1, 32'h100, 0, 5'd4, 5'd25, 1); step();
        idle(1); step();
        chk("cnt5", bus16.shift_cnt, 5);
        chk("cnt_sat", bus2.shift_cnt, 3);

        // Reset with a result held and a non-zero count
        send(3'd0, 32'h1, 0, 5'd1, 5'd26, 0); step();
        chk("pre_rst_valid", bus16.out_valid, 1);
        #1 rst = 1; bus16.in_valid = 0; step();
        chk_zeroed("mid_rst");
        #1 rst = 0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            #1;
            rst             = ($urandom_range(0, 299) == 0);
            bus16.flush     = ($urandom_range(0, 19) == 0);
            bus16.in_valid  = ($urandom_range(0, 9) < 7);
            bus16.out_ready = ($urandom_range(0, 9) < 7);
            bus16.in_op     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       bus16.in_rs = 32'h8000_0000;
                1:       bus16.in_rs = 32'hFFFF_FFFF;
                2:       bus16.in_rs = 32'h0;
                3:       bus16.in_rs = 32'h1;
                default: bus16.in_rs = $urandom;
            endcase
            bus16.in_rt  = $urandom;
            bus16.in_imm = 5'($urandom_range(0, 31));
            bus16.in_rd  = 5'($urandom_range(0, 31));
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
